du_arbiter: RTL and testbench
=============================

# du_arbiter

Round-robin arbiter and sequencer that shares the single `du` divider among `NUM_REQ` requesters in the HE datapath. It accepts one division request at a time over a valid/ready handshake, registers the operands, and pulses `du_start`. It then waits for `du_done`, captures quotient and remainder, and holds the result on a shared response bus until the granted requester accepts it. The block sits between the modular-reduction clients and the `du` instance, and is the only driver of `du`'s `start`/operand inputs.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥2.
- `IDW`, `$clog2(NUM_REQ)`: requester-ID width.
- `BIT_WIDTH` comes from `he_headers.sv`; `W` = `BIT_WIDTH`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: one-hot accept. Combinational: high only for the granted requester while in IDLE.
- `req_dividend` in `NUM_REQ*2*W`: packed dividends; requester i occupies bits `[i*2W +: 2W]`.
- `req_divisor` in `NUM_REQ*W`: packed divisors; requester i occupies bits `[i*W +: W]`.
- `resp_valid` out `NUM_REQ`: one-hot result valid for the owning requester.
- `resp_ready` in `NUM_REQ`: per-requester result accept.
- `resp_quotient` out `W`: result quotient.
- `resp_remainder` out `W`: result remainder.
- `resp_id` out `IDW`: index of the owning requester.
- `resp_err` out 1: divide-by-zero flag; only driven when `DU_ARB_DIV0_CHECK_EN` is defined, else tied 0.
- `busy` out 1: high in any state other than IDLE.
- `du_start` out 1: to `du.start`.
- `du_dividend` out `2W`: to `du.dividend`.
- `du_divisor` out `W`: to `du.divisor`.
- `du_quotient` in `W`: from `du.quotient`.
- `du_remainder` in `W`: from `du.remainder`.
- `du_done` in 1: from `du.done`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Grant is the first requester with `req_valid` high, searching from `rr_ptr` upward with wrap-around.
  - On handshake (`req_valid[g] & req_ready[g]`): register `g`, dividend and divisor; go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**
  - `du_start` is high for exactly this one cycle; go to WAIT.
- **WAIT**
  - Hold operands and wait for `du_done`. There is no timeout.
  - On `du_done`: register `du_quotient`/`du_remainder`; go to RESP.
  - `du_done` seen in any other state is ignored.
- **RESP**
  - `resp_valid[g]` is high with the registered data, which stays stable until accepted.
  - On `resp_ready[g]`: go to IDLE and set `rr_ptr = (g+1) mod NUM_REQ`.
  - `resp_ready` bits of other requesters are ignored.
- `du_dividend`/`du_divisor` are driven from the operand registers in every state, so `du` sees stable operands throughout its CALC cycle.
- One transaction is in flight at a time. Requests arriving outside IDLE wait; the requester must hold `req_valid` and its operands until accepted.
- Fairness: a requester that holds `req_valid` is granted within `NUM_REQ` transactions.
- A requester may issue a new request in the same cycle its response is accepted. It is eligible at the next IDLE cycle but ranks last under round-robin.

## Timing
- Reset (async, `rst`=0):
  - state=IDLE, `rr_ptr`=0.
  - Operand and result registers = 0.
  - Outputs: `req_ready` all 0, `resp_valid` all 0, `resp_*` = 0, `busy`=0, `du_start`=0, `du_*` = 0.
- Reset asserted mid-transaction aborts the transaction with no response. Any later `du_done` is ignored because the arbiter is then in IDLE.
- Latency with nominal `du`, request accepted in cycle T:
  - T+1: `du_start` high.
  - T+3: `du_done` high.
  - T+4: `resp_valid` high.
- Earliest next accept is the cycle after the `resp_ready` handshake, so back-to-back throughput is 5 cycles per division.
- RESP lasts at least one cycle, which guarantees `du` is back in READY before the next `du_start`.

## Configuration
- `DU_ARB_DIV0_CHECK_EN` defined:
  - A request with divisor 0 goes IDLE→RESP directly and never starts `du`.
  - Response: quotient = all ones, remainder = `dividend[W-1:0]`, `resp_err`=1, `resp_valid` at T+1.
  - Nonzero divisors respond with `resp_err`=0.
- `DU_ARB_DIV0_CHECK_EN` undefined:
  - Divisor 0 is issued to `du` like any other request.
  - `resp_err` is constant 0.

## Test plan
- Single request from requester 0, dividend=100, divisor=7 → `du_start` at T+1; `resp_valid[0]` at T+4 with quotient=14, remainder=2, `resp_id`=0.
- All 4 requesters hold valid continuously → grants in order 0,1,2,3,0. No requester is granted twice while another is pending.
- `resp_ready` held low 10 cycles → `resp_valid` and data stay stable. No `req_ready` is asserted until the handshake completes.
- Async `rst` pulsed low during WAIT → outputs go to 0 immediately. A trailing `du_done` produces no response. The next request (req 2, 50/5) returns quotient=10, remainder=0.
- With `DU_ARB_DIV0_CHECK_EN`, requester 1 sends dividend=9, divisor=0 → `du_start` never asserts; `resp_valid[1]` at T+1 with quotient=all ones, remainder=9, `resp_err`=1.
- Requester 3 re-requests in the same cycle its response is accepted, while requester 0 is also pending → requester 0 is granted next.

Source files
------------

// File: rtl/du_arbiter.sv
// du_arbiter: round-robin sequencer that shares one du divider among NUM_REQ requesters.
// Optional DU_ARB_DIV0_CHECK_EN: answers divide-by-zero locally without starting du.
module du_arbiter #(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned BIT_WIDTH = 32,
    localparam int unsigned IDW       = $clog2(NUM_REQ),
    localparam int unsigned W         = BIT_WIDTH,
    localparam int unsigned DW        = 2 * BIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_dividend,
    input  logic [NUM_REQ*W-1:0]  req_divisor,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [W-1:0]          resp_quotient,
    output logic [W-1:0]          resp_remainder,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  du_start,
    output logic [DW-1:0]         du_dividend,
    output logic [W-1:0]          du_divisor,
    input  logic [W-1:0]          du_quotient,
    input  logic [W-1:0]          du_remainder,
    input  logic                  du_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_id;
    logic [DW-1:0]        r_dividend;
    logic [W-1:0]         r_divisor;
    logic [W-1:0]         r_quot;
    logic [W-1:0]         r_rem;
    logic                 r_err;
    logic [NUM_REQ-1:0]   r_resp_valid;
    logic                 r_du_start;
    logic                 r_busy;

    logic                 w_any;
    logic [IDW-1:0]       w_grant;
    logic                 w_accept;
    logic                 w_resp_ack;
    logic                 w_div0;
    logic [IDW-1:0]       w_resp_id;
    logic [NUM_REQ-1:0]   w_resp_valid_nxt;
    logic [DW-1:0]        w_sel_dividend;
    logic [W-1:0]         w_sel_divisor;
    logic [DW-1:0]        w_dvd [NUM_REQ];
    logic [W-1:0]         w_dvs [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_dvd[g] = req_dividend[g*DW +: DW];
        assign w_dvs[g] = req_divisor[g*W +: W];
    end

    // First valid requester at or after r_ptr, wrapping around.
    always_comb begin : grant_search
        int unsigned idx;
        w_any   = 1'b0;
        w_grant = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(r_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_any && req_valid[IDW'(idx)]) begin
                w_any   = 1'b1;
                w_grant = IDW'(idx);
            end
        end
    end

    assign w_sel_dividend = w_dvd[w_grant];
    assign w_sel_divisor  = w_dvs[w_grant];
    assign w_accept       = (r_state == S_IDLE) && w_any;
    assign w_resp_ack     = (r_state == S_RESP) && resp_ready[r_id];
    assign w_resp_id      = (r_state == S_IDLE) ? w_grant : r_id;

`ifdef DU_ARB_DIV0_CHECK_EN
    assign w_div0 = (w_sel_divisor == '0);
`else
    assign w_div0 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_div0 ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (du_done) w_next = S_RESP;
            S_RESP:  if (w_resp_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_resp_valid_nxt = '0;
        if (w_next == S_RESP) begin
            w_resp_valid_nxt[w_resp_id] = 1'b1;
        end
    end

    // Operand/result capture and registered status outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_quot       <= '0;
            r_rem        <= '0;
            r_err        <= 1'b0;
            r_resp_valid <= '0;
            r_du_start   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_du_start   <= (w_next == S_ISSUE);
            r_busy       <= (w_next != S_IDLE);
            r_resp_valid <= w_resp_valid_nxt;
            if (w_accept) begin
                r_id       <= w_grant;
                r_dividend <= w_sel_dividend;
                r_divisor  <= w_sel_divisor;
            end
            if ((r_state == S_WAIT) && du_done) begin
                r_quot <= du_quotient;
                r_rem  <= du_remainder;
                r_err  <= 1'b0;
            end else if (w_accept && w_div0) begin
                r_quot <= '1;
                r_rem  <= w_sel_dividend[W-1:0];
                r_err  <= 1'b1;
            end
            if (w_resp_ack) begin
                r_ptr <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + IDW'(1);
            end
        end
    end

    assign resp_valid     = r_resp_valid;
    assign resp_quotient  = r_quot;
    assign resp_remainder = r_rem;
    assign resp_id        = r_id;
    assign resp_err       = r_err;
    assign busy           = r_busy;
    assign du_start       = r_du_start;
    assign du_dividend    = r_dividend;
    assign du_divisor     = r_divisor;

endmodule

// File: tb/tb_du_arbiter.sv
// Bench for du_arbiter: transaction-level model of the arbiter plus a nominal du divider model.
module tb_du_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_dividend;
    logic [N*W-1:0]    req_divisor;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [W-1:0]      resp_quotient;
    logic [W-1:0]      resp_remainder;
    logic [1:0]        resp_id;
    logic              resp_err;
    logic              busy;
    logic              du_start;
    logic [DW-1:0]     du_dividend;
    logic [W-1:0]      du_divisor;
    logic [W-1:0]      du_quotient  = '0;
    logic [W-1:0]      du_remainder = '0;
    logic              du_done      = 1'b0;

    du_arbiter #(.NUM_REQ(N), .BIT_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_id        (resp_id),
        .resp_err       (resp_err),
        .busy           (busy),
        .du_start       (du_start),
        .du_dividend    (du_dividend),
        .du_divisor     (du_divisor),
        .du_quotient    (du_quotient),
        .du_remainder   (du_remainder),
        .du_done        (du_done)
    );

    always #5 clk = ~clk;

    // Nominal du: start in cycle S, done (with results) in cycle S+2.
    logic          du_pend = 1'b0;
    logic [DW-1:0] du_a    = '0;
    logic [W-1:0]  du_b    = '0;
    always @(posedge clk) begin
        du_done <= 1'b0;
        if (du_pend) begin
            du_done <= 1'b1;
            du_pend <= 1'b0;
            if (du_b == '0) begin
                du_quotient  <= '1;
                du_remainder <= du_a[W-1:0];
            end else begin
                du_quotient  <= W'(du_a / DW'(du_b));
                du_remainder <= W'(du_a % DW'(du_b));
            end
        end
        if (du_start) begin
            du_pend <= 1'b1;
            du_a    <= du_dividend;
            du_b    <= du_divisor;
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int g_q[$];
    int g_acc[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Transaction-level model: one job in flight, response visible from a fixed cycle offset.
    logic          m_busy = 1'b0;
    int            m_ptr  = 0;
    int            m_id   = 0;
    int            m_acc  = 0;
    logic          m_div0 = 1'b0;
    logic [DW-1:0] m_a    = '0;
    logic [W-1:0]  m_b    = '0;
    logic [W-1:0]  m_q    = '0;
    logic [W-1:0]  m_r    = '0;
    logic          m_err  = 1'b0;
    int            gid;
    logic [N-1:0]  e_ready;
    logic [N-1:0]  e_rv;
    logic          e_rvld;
    logic          e_start;

    always begin
        @(negedge clk or negedge rst);
        if (!rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_a    = '0;
            m_b    = '0;
        end else begin
            gid = -1;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (gid < 0 && req_valid[i]) gid = i;
                end
            end
            e_ready = '0;
            if (gid >= 0) e_ready[gid] = 1'b1;
            e_start = m_busy && !m_div0 && (cyc == m_acc + 1);
            e_rvld  = m_busy && (cyc >= m_acc + (m_div0 ? 1 : 4));
            e_rv    = '0;
            if (e_rvld) e_rv[m_id] = 1'b1;

            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("du_start", 64'(du_start), 64'(e_start));
            chk("resp_valid", 64'(resp_valid), 64'(e_rv));
            chk("du_dividend", du_dividend, m_a);
            chk("du_divisor", 64'(du_divisor), 64'(m_b));
            if (e_rvld) begin
                chk("resp_quotient", 64'(resp_quotient), 64'(m_q));
                chk("resp_remainder", 64'(resp_remainder), 64'(m_r));
                chk("resp_id", 64'(resp_id), 64'(m_id));
                chk("resp_err", 64'(resp_err), 64'(m_err));
            end

            if (e_rvld && resp_ready[m_id]) begin
                m_busy = 1'b0;
                m_ptr  = (m_id + 1) % N;
            end else if (gid >= 0) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_id   = gid;
                m_a    = req_dividend[gid*DW +: DW];
                m_b    = req_divisor[gid*W +: W];
`ifdef DU_ARB_DIV0_CHECK_EN
                m_div0 = (m_b == '0);
`else
                m_div0 = 1'b0;
`endif
                m_err  = m_div0;
                if (m_b == '0) begin
                    m_q = '1;
                    m_r = m_a[W-1:0];
                end else begin
                    m_q = W'(m_a / DW'(m_b));
                    m_r = W'(m_a % DW'(m_b));
                end
                g_q.push_back(gid);
                g_acc.push_back(cyc);
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_on(input int id, input logic [DW-1:0] a, input logic [W-1:0] b);
        req_dividend[id*DW +: DW] = a;
        req_divisor[id*W +: W]    = b;
        req_valid[id]             = 1'b1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (g_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("grant_wait", 64'(g_q.size() >= n), 64'(1));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (m_busy && k < budget) begin
            tick();
            k++;
        end
        chk("idle_wait", 64'(m_busy), 64'(0));
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int base;
    int acc;
    int acc0;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        resp_ready   = '1;
        #1 rst = 1'b0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_du_start", 64'(du_start), 64'(0));
        chk("rst_du_dividend", du_dividend, 64'(0));
        chk("rst_du_divisor", 64'(du_divisor), 64'(0));
        chk("rst_quotient", 64'(resp_quotient), 64'(0));
        chk("rst_remainder", 64'(resp_remainder), 64'(0));
        chk("rst_id_err", 64'({resp_id, resp_err}), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // All requesters continuously valid.
        base = g_q.size();
        for (int i = 0; i < N; i++) req_on(i, 64'(1000 + i * 37), 32'(i + 3));
        wait_grants(base + 5, 60);
        req_valid = '0;
        if (g_q.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", 64'(g_q[base+k]), 64'(exp_order[k]));
            for (int k = 0; k < 4; k++) chk("rr_spacing", 64'(g_acc[base+k+1] - g_acc[base+k]), 64'(5));
        end
        wait_idle(20);

        // Single request 100/7 from requester 0.
        base = g_q.size();
        req_on(0, 64'd100, 32'd7);
        wait_grants(base + 1, 20);
        req_valid[0] = 1'b0;
        acc = g_acc[base];
        wait_until(acc + 1);
        chk("single_start", 64'(du_start), 64'(1));
        wait_until(acc + 3);
        chk("single_early", 64'(resp_valid), 64'(0));
        wait_until(acc + 4);
        chk("single_valid", 64'(resp_valid), 64'(4'b0001));
        chk("single_q", 64'(resp_quotient), 64'(14));
        chk("single_r", 64'(resp_remainder), 64'(2));
        chk("single_id", 64'(resp_id), 64'(0));
        chk("single_err", 64'(resp_err), 64'(0));
        wait_idle(20);

        // Response stall with foreign resp_ready bits high and another request pending.
        resp_ready = 4'b1101;
        base = g_q.size();
        req_on(1, 64'd12345, 32'd100);
        req_on(2, 64'd77, 32'd8);
        wait_grants(base + 1, 20);
        req_valid[1] = 1'b0;
        acc = g_acc[base];
        chk("stall_gid", 64'(g_q[base]), 64'(1));
        wait_until(acc + 4);
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", 64'(resp_valid), 64'(4'b0010));
            chk("stall_q", 64'(resp_quotient), 64'(123));
            chk("stall_r", 64'(resp_remainder), 64'(45));
            chk("stall_ready", 64'(req_ready), 64'(0));
            tick();
        end
        resp_ready = '1;
        wait_grants(base + 2, 20);
        req_valid[2] = 1'b0;
        chk("stall_next_gid", 64'(g_q[base+1]), 64'(2));
        chk("stall_next_cyc", 64'(g_acc[base+1] - acc), 64'(15));
        wait_idle(20);

        // Asynchronous reset while waiting on du.
        base = g_q.size();
        req_on(0, 64'd500, 32'd3);
        wait_grants(base + 1, 20);
        req_valid[0] = 1'b0;
        acc = g_acc[base];
        wait_until(acc + 2);
        rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_start", 64'(du_start), 64'(0));
        chk("arst_dividend", du_dividend, 64'(0));
        chk("arst_divisor", 64'(du_divisor), 64'(0));
        chk("arst_resp", 64'({resp_valid, resp_quotient}), 64'(0));
        #1 rst = 1'b1;
        wait_until(acc + 4);
        chk("trail_valid", 64'(resp_valid), 64'(0));
        chk("trail_busy", 64'(busy), 64'(0));
        tick();
        chk("trail_valid2", 64'(resp_valid), 64'(0));
        base = g_q.size();
        req_on(2, 64'd50, 32'd5);
        wait_grants(base + 1, 20);
        req_valid[2] = 1'b0;
        acc = g_acc[base];
        chk("post_rst_gid", 64'(g_q[base]), 64'(2));
        wait_until(acc + 4);
        chk("post_rst_valid", 64'(resp_valid), 64'(4'b0100));
        chk("post_rst_q", 64'(resp_quotient), 64'(10));
        chk("post_rst_r", 64'(resp_remainder), 64'(0));
        chk("post_rst_id", 64'(resp_id), 64'(2));
        wait_idle(20);

        // Requester 3 re-requests as its response is accepted; requester 0 pending.
        base = g_q.size();
        req_on(3, 64'd200, 32'd9);
        req_on(0, 64'd60, 32'd7);
        wait_grants(base + 1, 20);
        req_valid[3] = 1'b0;
        acc = g_acc[base];
        chk("rereq_first", 64'(g_q[base]), 64'(3));
        wait_until(acc + 4);
        chk("rereq_q3", 64'(resp_quotient), 64'(22));
        req_on(3, 64'd81, 32'd4);
        wait_grants(base + 2, 20);
        req_valid[0] = 1'b0;
        chk("rereq_second", 64'(g_q[base+1]), 64'(0));
        chk("rereq_second_cyc", 64'(g_acc[base+1] - acc), 64'(5));
        acc0 = g_acc[base+1];
        wait_until(acc0 + 4);
        chk("rereq_q0", 64'(resp_quotient), 64'(8));
        chk("rereq_r0", 64'(resp_remainder), 64'(4));
        wait_grants(base + 3, 20);
        req_valid[3] = 1'b0;
        chk("rereq_third", 64'(g_q[base+2]), 64'(3));
        wait_idle(20);

`ifdef DU_ARB_DIV0_CHECK_EN
        // Divide-by-zero answered locally.
        base = g_q.size();
        req_on(1, 64'd9, 32'd0);
        wait_grants(base + 1, 20);
        req_valid[1] = 1'b0;
        acc = g_acc[base];
        wait_until(acc + 1);
        chk("div0_valid", 64'(resp_valid), 64'(4'b0010));
        chk("div0_q", 64'(resp_quotient), 64'(32'hFFFF_FFFF));
        chk("div0_r", 64'(resp_remainder), 64'(9));
        chk("div0_err", 64'(resp_err), 64'(1));
        chk("div0_start", 64'(du_start), 64'(0));
        wait_idle(20);
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
